// File: rtl/status_led.sv
// status_led: test-fixture status FSM driving a blinking / steady PWM-dimmed RGB LED.
module status_led #(
    parameter int CLK_FREQ = 48_000_000,
    parameter int BLINK_HZ = 2,
    parameter int PWM_BITS = 8,
    parameter int DUTY     = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_running,
    input  logic       i_passed,
    output logic       o_led_r,
    output logic       o_led_g,
    output logic       o_led_b,
    output logic [1:0] o_state
);
    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
    localparam int HALF = CLK_FREQ / (2 * BLINK_HZ);
    localparam int BW = HALF > 1 ? $clog2(HALF) : 1;
    localparam logic [BW-1:0] LAST = BW'(HALF - 1);
    localparam logic [PWM_BITS-1:0] DUTY_V = PWM_BITS'(DUTY);
    state_t state, state_n;
    logic [BW-1:0] blink_cnt;
    logic phase;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic pwm_on;
    always_comb begin
        state_n = i_running ? RUN : (state == RUN) ? (i_passed ? PASS : FAIL) : state;
    end
    assign pwm_on  = pwm_cnt < DUTY_V;
    assign o_state = state;
    // LEDs are decoded from the current state, so they trail o_state by one cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            blink_cnt <= '0;
            phase     <= 1'b1;
            pwm_cnt   <= '0;
            o_led_r   <= 1'b0;
            o_led_g   <= 1'b0;
            o_led_b   <= 1'b0;
        end else begin
            state   <= state_n;
            pwm_cnt <= pwm_cnt + 1'b1;
            o_led_b <= (state == RUN) & phase & pwm_on;
            o_led_g <= (state == PASS) & pwm_on;
            o_led_r <= (state == FAIL) & phase & pwm_on;
            if (state_n != state) begin
                blink_cnt <= '0;
                phase     <= 1'b1;
            end else if (blink_cnt == LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
endmodule
